e203_exu_longpwbck_mc: RTL

Multi-channel long-pipe write-back arbiter with a registered output slot. It sits between the long-pipe units (LSU, NICE, future divider/FPU) and the final write-back and commit stages. Each cycle it retires at most one long-pipe instruction in strict OITF order. Results are captured into a one-entry slot whose write-back and exception handshakes complete independently.

---
 rtl/e203_exu_longpwbck_mc_pkg.sv | 15 +
 rtl/e203_exu_longpwbck_slot.sv | 90 +++++++++
 rtl/e203_exu_longpwbck_mc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/e203_exu_longpwbck_mc_pkg.sv
// Shared types and constants for the long-pipe write-back arbiter.
package e203_exu_longpwbck_mc_pkg;

  localparam int WBCK_FLAGS_W = 5;
  localparam int NCH_MAX      = 8;

  // Width-independent slot qualifiers; the wide payload fields follow the top-level parameters.
  typedef struct packed {
    logic rdfpu;
    logic ld;
    logic st;
    logic buserr;
  } slot_qual_t;

endpackage

// File: rtl/e203_exu_longpwbck_slot.sv
// One-entry write-back/exception slot with independently handshaked pending bits.
module e203_exu_longpwbck_slot
  import e203_exu_longpwbck_mc_pkg::*;
#(
  parameter int FLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               ld_wb,
  input  logic               ld_ex,
  input  logic [FLEN-1:0]    ld_wdat,
  input  logic [RFIDX_W-1:0] ld_rdidx,
  input  logic [PC_W-1:0]    ld_pc,
  input  logic [ADDR_W-1:0]  ld_badaddr,
  input  slot_qual_t         ld_qual,
  input  logic               wb_ready,
  input  logic               ex_ready,
  output logic               wb_pend,
  output logic               ex_pend,
  output logic               avail,
  output logic [FLEN-1:0]    wdat,
  output logic [RFIDX_W-1:0] rdidx,
  output logic [PC_W-1:0]    pc,
  output logic [ADDR_W-1:0]  badaddr,
  output slot_qual_t         qual
);

  logic               wb_pend_q, wb_pend_d;
  logic               ex_pend_q, ex_pend_d;
  logic [FLEN-1:0]    wdat_q, wdat_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]  badaddr_q, badaddr_d;
  slot_qual_t         qual_q, qual_d;

  // Free or freeing: nothing pending survives this cycle's handshakes.
  assign avail = ~(wb_pend_q & ~wb_ready) & ~(ex_pend_q & ~ex_ready);

  always_comb begin
    wb_pend_d = wb_pend_q & ~wb_ready;
    ex_pend_d = ex_pend_q & ~ex_ready;
    wdat_d    = wdat_q;
    rdidx_d   = rdidx_q;
    pc_d      = pc_q;
    badaddr_d = badaddr_q;
    qual_d    = qual_q;
    if (load) begin
      wb_pend_d = ld_wb;
      ex_pend_d = ld_ex;
      wdat_d    = ld_wdat;
      rdidx_d   = ld_rdidx;
      pc_d      = ld_pc;
      badaddr_d = ld_badaddr;
      qual_d    = ld_qual;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pend_q <= 1'b0;
      ex_pend_q <= 1'b0;
      wdat_q    <= '0;
      rdidx_q   <= '0;
      pc_q      <= '0;
      badaddr_q <= '0;
      qual_q    <= '0;
    end else begin
      wb_pend_q <= wb_pend_d;
      ex_pend_q <= ex_pend_d;
      wdat_q    <= wdat_d;
      rdidx_q   <= rdidx_d;
      pc_q      <= pc_d;
      badaddr_q <= badaddr_d;
      qual_q    <= qual_d;
    end
  end

  assign wb_pend = wb_pend_q;
  assign ex_pend = ex_pend_q;
  assign wdat    = wdat_q;
  assign rdidx   = rdidx_q;
  assign pc      = pc_q;
  assign badaddr = badaddr_q;
  assign qual    = qual_q;

endmodule

// File: rtl/e203_exu_longpwbck_mc.sv
// Multi-channel long-pipe write-back arbiter: retires the oldest OITF entry from the
// lowest-index matching channel into a registered slot.
module e203_exu_longpwbck_mc
  import e203_exu_longpwbck_mc_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int XLEN    = 32,
  parameter int FLEN    = 32,
  parameter int ITAG_W  = 1,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32,
  parameter int ADDR_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_valid_i,
  output logic [NCH-1:0]          ch_ready_o,
  input  logic [NCH*XLEN-1:0]     ch_wdat_i,
  input  logic [NCH*ITAG_W-1:0]   ch_itag_i,
  input  logic [NCH-1:0]          ch_err_i,
  input  logic [NCH-1:0]          ch_buserr_i,
  input  logic [NCH-1:0]          ch_ld_i,
  input  logic [NCH-1:0]          ch_st_i,
  input  logic [NCH*ADDR_W-1:0]   ch_badaddr_i,
  input  logic                    oitf_empty,
  input  logic [ITAG_W-1:0]       oitf_ret_ptr,
  input  logic [RFIDX_W-1:0]      oitf_ret_rdidx,
  input  logic [PC_W-1:0]         oitf_ret_pc,
  input  logic                    oitf_ret_rdwen,
  input  logic                    oitf_ret_rdfpu,
  output logic                    oitf_ret_ena,
  output logic                    longp_wbck_o_valid,
  input  logic                    longp_wbck_o_ready,
  output logic [FLEN-1:0]         longp_wbck_o_wdat,
  output logic [WBCK_FLAGS_W-1:0] longp_wbck_o_flags,
  output logic [RFIDX_W-1:0]      longp_wbck_o_rdidx,
  output logic                    longp_wbck_o_rdfpu,
  output logic                    longp_excp_o_valid,
  input  logic                    longp_excp_o_ready,
  output logic                    longp_excp_o_insterr,
  output logic                    longp_excp_o_ld,
  output logic                    longp_excp_o_st,
  output logic                    longp_excp_o_buserr,
  output logic [ADDR_W-1:0]       longp_excp_o_badaddr,
  output logic [PC_W-1:0]         longp_excp_o_pc,
  output logic                    dup_err_o
);

  logic [NCH-1:0]    match, sel_oh;
  logic              accept, slot_avail;
  logic              sel_err, sel_ld, sel_st, sel_buserr;
  logic [XLEN-1:0]   sel_wdat;
  logic [ADDR_W-1:0] sel_badaddr;
  slot_qual_t        ld_qual, out_qual;
  logic              dup_err_q, dup_err_d;

  for (genvar k = 0; k < NCH; k++) begin : g_match
    assign match[k] = ch_valid_i[k] & ~oitf_empty
                    & (ch_itag_i[k*ITAG_W +: ITAG_W] == oitf_ret_ptr);
  end

  // Isolate the lowest set bit: channel 0 wins tag collisions.
  assign sel_oh = match & (~match + NCH'(1));

  always_comb begin
    sel_err     = 1'b0;
    sel_ld      = 1'b0;
    sel_st      = 1'b0;
    sel_buserr  = 1'b0;
    sel_wdat    = '0;
    sel_badaddr = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_oh[k]) begin
        sel_err     = ch_err_i[k];
        sel_ld      = ch_ld_i[k];
        sel_st      = ch_st_i[k];
        sel_buserr  = ch_buserr_i[k];
        sel_wdat    = ch_wdat_i[k*XLEN +: XLEN];
        sel_badaddr = ch_badaddr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign accept       = (|match) & slot_avail;
  assign oitf_ret_ena = accept;
  assign ch_ready_o   = sel_oh & {NCH{accept}};

  always_comb begin
    ld_qual        = '0;
    ld_qual.rdfpu  = oitf_ret_rdfpu;
    ld_qual.ld     = sel_ld & sel_err;
    ld_qual.st     = sel_st & sel_err;
    ld_qual.buserr = sel_buserr & sel_err;
  end

  e203_exu_longpwbck_slot #(
    .FLEN(FLEN), .RFIDX_W(RFIDX_W), .PC_W(PC_W), .ADDR_W(ADDR_W)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .ld_wb      (oitf_ret_rdwen & ~sel_err),
    .ld_ex      (sel_err),
    .ld_wdat    (FLEN'(sel_wdat)),
    .ld_rdidx   (oitf_ret_rdidx),
    .ld_pc      (oitf_ret_pc),
    .ld_badaddr (sel_err ? sel_badaddr : '0),
    .ld_qual    (ld_qual),
    .wb_ready   (longp_wbck_o_ready),
    .ex_ready   (longp_excp_o_ready),
    .wb_pend    (longp_wbck_o_valid),
    .ex_pend    (longp_excp_o_valid),
    .avail      (slot_avail),
    .wdat       (longp_wbck_o_wdat),
    .rdidx      (longp_wbck_o_rdidx),
    .pc         (longp_excp_o_pc),
    .badaddr    (longp_excp_o_badaddr),
    .qual       (out_qual)
  );

  assign dup_err_d = dup_err_q | ($countones(match) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dup_err_q <= 1'b0;
    else     dup_err_q <= dup_err_d;
  end

  assign dup_err_o            = dup_err_q;
  assign longp_wbck_o_flags   = '0;
  assign longp_wbck_o_rdfpu   = out_qual.rdfpu;
  assign longp_excp_o_insterr = 1'b0;
  assign longp_excp_o_ld      = out_qual.ld;
  assign longp_excp_o_st      = out_qual.st;
  assign longp_excp_o_buserr  = out_qual.buserr;

endmodule
